// File: rtl/sensor_adc_sequencer.sv
// Sequences one sensor measurement: config/power, settle, ADC trigger, capture or timeout.
// done follows the accepted start by SENS_SETTLE_TICKS + k + 1 edges; abort returns to IDLE silently.
module sensor_adc_sequencer #(
  parameter int SENS_SETTLE_TICKS = 256,
  parameter int ADC_TIMEOUT_TICKS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cfg,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] result,
  output logic [2:0]  sens_config,
  output logic        sens_enable,
  output logic        sens_read,
  output logic        adc_enable,
  output logic        adc_read,
  input  logic        adc_conversion_complete,
  input  logic [15:0] adc_value
);

  localparam int MAX_TICKS = (SENS_SETTLE_TICKS > ADC_TIMEOUT_TICKS) ?
                             SENS_SETTLE_TICKS : ADC_TIMEOUT_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SENS_SETTLE_TICKS - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ADC_TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT} state_t;

  state_t       state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         busy_q, done_q, timeout_q;
  logic [15:0]  result_q;
  logic [2:0]   sens_config_q;
  logic         sens_enable_q, sens_read_q, adc_enable_q, adc_read_q;

  // Saturating increment: the counter never wraps back into a live compare value.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      result_q      <= 16'h0000;
      sens_config_q <= 3'b000;
      sens_enable_q <= 1'b0;
      sens_read_q   <= 1'b0;
      adc_enable_q  <= 1'b0;
      adc_read_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      adc_read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            sens_config_q <= cfg;
            sens_enable_q <= 1'b1;
            busy_q        <= 1'b1;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
            state_q       <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            sens_enable_q <= 1'b0;
            sens_read_q   <= 1'b0;
            adc_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (cnt_q == SETTLE_LAST) begin
            sens_read_q  <= 1'b1;
            adc_enable_q <= 1'b1;
            adc_read_q   <= 1'b1;
            cnt_q        <= '0;
            state_q      <= CONVERT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        CONVERT: begin
          // The first CONVERT cycle (cnt_q == 0) ignores complete to reject a stale flag.
          if (abort) begin
            sens_enable_q <= 1'b0;
            sens_read_q   <= 1'b0;
            adc_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (cnt_q != '0 && adc_conversion_complete) begin
            result_q      <= adc_value;
            done_q        <= 1'b1;
            sens_enable_q <= 1'b0;
            sens_read_q   <= 1'b0;
            adc_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            result_q      <= 16'hFFFF;
            timeout_q     <= 1'b1;
            done_q        <= 1'b1;
            sens_enable_q <= 1'b0;
            sens_read_q   <= 1'b0;
            adc_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign result      = result_q;
  assign sens_config = sens_config_q;
  assign sens_enable = sens_enable_q;
  assign sens_read   = sens_read_q;
  assign adc_enable  = adc_enable_q;
  assign adc_read    = adc_read_q;

endmodule

// File: tb/tb_sensor_adc_sequencer.sv
// Directed bench for sensor_adc_sequencer with SENS_SETTLE_TICKS=4, ADC_TIMEOUT_TICKS=8.
// Ek denotes the k-th rising edge after (and including) the start-accepting edge E0.
module tb_sensor_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg = 3'b000;
  logic        abort = 1'b0;
  logic        busy, done, timeout;
  logic [15:0] result;
  logic [2:0]  sens_config;
  logic        sens_enable, sens_read, adc_enable, adc_read;
  logic        adc_conversion_complete = 1'b0;
  logic [15:0] adc_value = 16'h0000;

  int errors = 0;
  int checks = 0;

  sensor_adc_sequencer #(
    .SENS_SETTLE_TICKS(4),
    .ADC_TIMEOUT_TICKS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg(cfg),
    .abort(abort),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .result(result),
    .sens_config(sens_config),
    .sens_enable(sens_enable),
    .sens_read(sens_read),
    .adc_enable(adc_enable),
    .adc_read(adc_read),
    .adc_conversion_complete(adc_conversion_complete),
    .adc_value(adc_value)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if ({busy, done, timeout, result, sens_config, sens_enable, sens_read, adc_enable, adc_read} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got=%h required=0", {busy, done, timeout, result, sens_config, sens_enable, sens_read, adc_enable, adc_read}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal(input string tag);
    cfg = 3'b101; start = 1'b1;
    step(); // E0
    start = 1'b0; cfg = 3'b000;
    checks++; if (sens_config !== 3'd5) begin errors++; $display("FAIL %s cfg got=%0d required=5", tag, sens_config); end
    checks++; if ({busy, sens_enable, sens_read, adc_enable, adc_read} !== 5'b11000) begin
      errors++; $display("FAIL %s e0_flags got=%b required=11000", tag, {busy, sens_enable, sens_read, adc_enable, adc_read}); end
    step(); step(); step(); // E3
    checks++; if (adc_read !== 1'b0) begin errors++; $display("FAIL %s e3_adc_read got=%b required=0", tag, adc_read); end
    step(); // E4
    checks++; if ({sens_enable, sens_read, adc_enable, adc_read} !== 4'b1111) begin
      errors++; $display("FAIL %s e4_flags got=%b required=1111", tag, {sens_enable, sens_read, adc_enable, adc_read}); end
    step(); // E5
    checks++; if ({sens_read, adc_enable, adc_read} !== 3'b110) begin
      errors++; $display("FAIL %s e5_flags got=%b required=110", tag, {sens_read, adc_enable, adc_read}); end
    step(); // E6, now in 3rd CONVERT cycle
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s e6_done got=%b required=0", tag, done); end
    adc_conversion_complete = 1'b1; adc_value = 16'hA5C3;
    step(); // E7
    adc_conversion_complete = 1'b0; adc_value = 16'h0000;
    checks++; if ({done, timeout, busy} !== 3'b100) begin
      errors++; $display("FAIL %s e7_done_to_busy got=%b required=100", tag, {done, timeout, busy}); end
    checks++; if (result !== 16'hA5C3) begin errors++; $display("FAIL %s result got=%h required=a5c3", tag, result); end
    checks++; if ({sens_enable, sens_read, adc_enable, adc_read} !== 4'b0000) begin
      errors++; $display("FAIL %s e7_enables got=%b required=0000", tag, {sens_enable, sens_read, adc_enable, adc_read}); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got=%b required=0", tag, done); end
    checks++; if (sens_config !== 3'd5) begin errors++; $display("FAIL %s cfg_hold got=%0d required=5", tag, sens_config); end
  endtask

  task automatic test_timeout();
    cfg = 3'b010; start = 1'b1;
    step(); // E0
    start = 1'b0;
    for (int i = 1; i <= 11; i++) step();
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL to_e11 got=%b required=01", {done, busy}); end
    step(); // E12
    checks++; if ({done, timeout, busy} !== 3'b110) begin
      errors++; $display("FAIL to_e12 got=%b required=110", {done, timeout, busy}); end
    checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL to_result got=%h required=ffff", result); end
    checks++; if ({sens_enable, sens_read, adc_enable} !== 3'b000) begin
      errors++; $display("FAIL to_enables got=%b required=000", {sens_enable, sens_read, adc_enable}); end
    step(); step(); step();
    checks++; if ({done, timeout} !== 2'b01) begin errors++; $display("FAIL to_hold got=%b required=01", {done, timeout}); end
  endtask

  task automatic test_stale_complete();
    adc_conversion_complete = 1'b1; adc_value = 16'h1234;
    cfg = 3'b011; start = 1'b1;
    step(); // E0
    start = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stale_to_clear got=%b required=0", timeout); end
    step(); step(); step(); step(); // E4
    checks++; if ({adc_read, done} !== 2'b10) begin errors++; $display("FAIL stale_e4 got=%b required=10", {adc_read, done}); end
    step(); // E5: flag ignored in the adc_read cycle
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL stale_e5 got=%b required=01", {done, busy}); end
    step(); // E6
    adc_conversion_complete = 1'b0;
    checks++; if ({done, timeout, busy} !== 3'b100) begin
      errors++; $display("FAIL stale_e6 got=%b required=100", {done, timeout, busy}); end
    checks++; if (result !== 16'h1234) begin errors++; $display("FAIL stale_result got=%h required=1234", result); end
    step();
  endtask

  task automatic test_abort();
    int seen_done = 0;
    cfg = 3'b110; start = 1'b1;
    step(); // E0
    start = 1'b0;
    step(); // E1, now in 2nd SETTLE cycle
    abort = 1'b1;
    step(); // E2
    abort = 1'b0;
    checks++; if ({busy, sens_enable, sens_read, adc_enable, adc_read, done} !== 6'd0) begin
      errors++; $display("FAIL abort_settle got=%b required=000000", {busy, sens_enable, sens_read, adc_enable, adc_read, done}); end
    checks++; if ({result, timeout} !== {16'h1234, 1'b0}) begin
      errors++; $display("FAIL abort_result got=%h/%b required=1234/0", result, timeout); end
    for (int i = 0; i < 12; i++) begin step(); if (done) seen_done++; end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done got=%0d required=0", seen_done); end
    // abort and start together in IDLE: start dropped
    abort = 1'b1; start = 1'b1;
    step();
    checks++; if ({busy, sens_enable} !== 2'b00) begin errors++; $display("FAIL abort_wins got=%b required=00", {busy, sens_enable}); end
    abort = 1'b0;
    // start kept high through SETTLE must not restart it
    step(); // E0 with start still high
    step(); step(); step(); step(); // E4
    checks++; if (adc_read !== 1'b1) begin errors++; $display("FAIL start_ignored got=%b required=1", adc_read); end
    start = 1'b0;
    abort = 1'b1;
    step(); // abort in CONVERT
    abort = 1'b0;
    checks++; if ({busy, sens_enable, sens_read, adc_enable, done} !== 5'd0) begin
      errors++; $display("FAIL abort_convert got=%b required=00000", {busy, sens_enable, sens_read, adc_enable, done}); end
    step();
  endtask

  task automatic test_race();
    cfg = 3'b001; start = 1'b1;
    step(); // E0
    start = 1'b0;
    for (int i = 1; i <= 11; i++) step(); // E11, 8th CONVERT cycle follows
    adc_conversion_complete = 1'b1; adc_value = 16'hBEEF;
    step(); // E12
    adc_conversion_complete = 1'b0;
    checks++; if ({done, timeout, busy} !== 3'b100) begin
      errors++; $display("FAIL race_flags got=%b required=100", {done, timeout, busy}); end
    checks++; if (result !== 16'hBEEF) begin errors++; $display("FAIL race_result got=%h required=beef", result); end
    step();
  endtask

  task automatic test_reset_mid_convert();
    cfg = 3'b111; start = 1'b1;
    step(); // E0
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step(); // E5, inside CONVERT
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, timeout, result, sens_config, sens_enable, sens_read, adc_enable, adc_read} !== 26'd0) begin
      errors++; $display("FAIL rst_async got=%h required=0", {busy, done, timeout, result, sens_config, sens_enable, sens_read, adc_enable, adc_read}); end
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_held got=%b required=00", {busy, done}); end
    rst_n = 1'b1;
    step();
    test_nominal("post_rst");
  endtask

  initial begin
    test_reset();
    test_nominal("nominal");
    test_timeout();
    test_stale_complete();
    test_abort();
    test_race();
    test_reset_mid_convert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_adc_sequencer.md
Name: sensor_adc_sequencer

Overview:
Sequences one sensor measurement: applies config, powers the sensor, waits a settle time, triggers the ADC, then captures the result or times out. Sits directly downstream of the adapter's command decode. It takes a one-cycle start request plus a 3-bit config and drives the sensor and ADC pins at the top level. It returns a 16-bit result with done and timeout flags to the adapter for the 14443-4 reply.

Parameters:
SENS_SETTLE_TICKS, 256, clk cycles the sensor is enabled before sampling; must be >= 1.
ADC_TIMEOUT_TICKS, 4096, maximum clk cycles spent in CONVERT waiting for completion; must be >= 2.

Ports:
clk  input  1  13.56 MHz recovered carrier clock; may stop during pauses.
rst_n  input  1  asynchronous active-low reset.
start  input  1  measurement request, sampled each edge.
cfg  input  3  sensor configuration, sampled with an accepted start.
abort  input  1  cancels any measurement in progress.
busy  output  1  high whenever state != IDLE (registered).
done  output  1  one-cycle pulse when a measurement finishes (capture or timeout).
timeout  output  1  high if the last measurement timed out; valid from done until the next accepted start.
result  output  16  last captured ADC value; 16'hFFFF after a timeout.
sens_config  output  3  latched cfg.
sens_enable  output  1  sensor power enable.
sens_read  output  1  sensor output connected to the ADC.
adc_enable  output  1  ADC power enable.
adc_read  output  1  one-cycle conversion trigger.
adc_conversion_complete  input  1  ADC level flag, synchronous to clk.
adc_value  input  16  ADC sample, valid while complete is high.

Behaviour:
- Reset values: all outputs 0. result = 16'h0000, sens_config = 3'b000, state IDLE. Reset mid-operation returns immediately to these values; no done is produced.
- States: IDLE, SETTLE, CONVERT. All outputs are registered.
- IDLE
  - At an edge where start=1 and abort=0: sens_config<=cfg, sens_enable<=1, busy<=1, timeout<=0, counter<=0, go to SETTLE.
  - start is ignored in SETTLE and CONVERT.
  - start is accepted in the same cycle that done is high.
- SETTLE
  - Lasts exactly SENS_SETTLE_TICKS cycles.
  - On the edge that ends it: sens_read<=1, adc_enable<=1, adc_read<=1, counter<=0, go to CONVERT.
- CONVERT
  - adc_read is high only in the first CONVERT cycle. sens_enable, sens_read and adc_enable stay high throughout.
  - adc_conversion_complete is ignored in the first CONVERT cycle, so a stale flag from a previous conversion is rejected. It is sampled from the second cycle on.
  - Complete sampled high: result<=adc_value, done<=1 for one cycle, timeout stays 0, all sensor/ADC enables<=0, busy<=0, go to IDLE.
  - Counter reaches ADC_TIMEOUT_TICKS CONVERT cycles with no completion: result<=16'hFFFF, timeout<=1, done pulse, enables<=0, go to IDLE.
  - Complete seen on the same edge the timeout expires: treated as a normal capture (timeout=0).
- abort
  - In any non-IDLE state: go to IDLE at the next edge with enables and busy low. No done; result and timeout unchanged.
  - abort together with start in IDLE: abort wins and start is dropped.
- sens_config holds its value after completion until the next accepted start.
- Counter width is $clog2(max(SENS_SETTLE_TICKS, ADC_TIMEOUT_TICKS)+1). It saturates and never wraps.
- Latency: done follows start by SENS_SETTLE_TICKS + k + 1 edges, where k (>= 2) is the CONVERT cycle in which completion is sampled.
- Clock stop (carrier pause): state simply freezes; no special handling is required.

Test Plan:
(Bench parameters: SENS_SETTLE_TICKS=4, ADC_TIMEOUT_TICKS=8. Ek is the k-th clock edge, with the start-accepting edge as E0.)
1. Nominal capture. Stimulus: start with cfg=3'b101 at E0; complete=1 with adc_value=16'hA5C3 during the 3rd CONVERT cycle. Required: sens_config=5 and sens_enable=1 after E0; sens_read, adc_enable and adc_read=1 after E4; adc_read=0 after E5; done=1 for one cycle after E7; result=16'hA5C3; timeout=0; all enables 0.
2. Timeout. Stimulus: complete never asserts. Required: done=1 and timeout=1 after E12; result=16'hFFFF; busy=0; timeout stays 1 until the next start.
3. Stale complete. Stimulus: complete held high from before start. Required: ignored in the adc_read cycle; captured at E6; done after E6.
4. Abort. Stimulus: abort during the 2nd SETTLE cycle. Required: all enables and busy 0 after that edge; no done; result unchanged. A start asserted during SETTLE/CONVERT has no effect.
5. Race. Stimulus: complete first asserted in the 8th CONVERT cycle. Required: capture wins; timeout=0; result=adc_value.
6. Reset mid-CONVERT. Stimulus: rst_n low asynchronously. Required: all outputs 0 immediately, without waiting for a clk edge; a fresh start afterwards runs scenario 1 timing exactly.
